// File: rtl/sound_pong.sv
// -----------------------------------------------------------------------------
// sound_pong
//
// Tone generator for the pong game. It takes the sound-event code from the
// game-dynamics block and plays a square wave on a 1-bit speaker pin:
//   code 01 (pong) : one low note   (PONG_HALF half-period)
//   code 10 (ping) : one high note  (PING_HALF half-period)
//   code 11 (go)   : low note, silent gap, high note
//   code 00 (stop) : no sound; aborts whatever is playing
//
// A note starts when the synchronised code changes to a non-zero value, or
// when trig replays the current non-zero code. A new start always restarts
// the first note, even in the middle of another note or gap.
//
// Parameters (all lengths in clk cycles, each >= 1 and < 2**CW):
//   PING_HALF  half-period of the high tone
//   PONG_HALF  half-period of the low tone
//   DUR        length of one note
//   GAP        silence between the two notes of the go jingle
//   CW         width of the half-period and duration counters
//
// Ports:
//   clk         system clock
//   clr         asynchronous, active-high reset
//   code_sound  event code, asynchronous to clk
//   mute        silences speaker only; sequencing is unaffected
//   trig        one-cycle pulse, synchronous to clk; replays the current code
//   speaker     registered square-wave output
//   busy        high while a note or the gap is in progress
//   cur_code    code being played, 00 when idle
// -----------------------------------------------------------------------------
module sound_pong #(
   parameter int PING_HALF = 6818,
   parameter int PONG_HALF = 13636,
   parameter int DUR       = 600000,
   parameter int GAP       = 120000,
   parameter int CW        = 24
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] code_sound,
   input  logic       mute,
   input  logic       trig,
   output logic       speaker,
   output logic       busy,
   output logic [1:0] cur_code
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_NOTE1 = 2'd1,
      S_GAP   = 2'd2,
      S_NOTE2 = 2'd3
   } state_t;

   localparam logic [1:0] CODE_STOP = 2'b00;
   localparam logic [1:0] CODE_PING = 2'b10;
   localparam logic [1:0] CODE_GO   = 2'b11;

   // Counter load values: counters run from N-1 down to 0, giving N cycles.
   localparam logic [CW-1:0] PING_LD = CW'(PING_HALF - 1);
   localparam logic [CW-1:0] PONG_LD = CW'(PONG_HALF - 1);
   localparam logic [CW-1:0] DUR_LD  = CW'(DUR - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   // ---------------------------------------------------------------------------
   // Input synchroniser and previous-code register
   // ---------------------------------------------------------------------------
   logic [1:0] sync1_q;   // first synchroniser stage, may be metastable
   logic [1:0] code_s_q;  // synchronised code
   logic [1:0] code_p_q;  // code_s one cycle earlier, for change detection

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others, whatever the statement order.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1_q  <= CODE_STOP;
         code_s_q <= CODE_STOP;
         code_p_q <= CODE_STOP;
      end else begin
         sync1_q  <= code_sound;
         code_s_q <= sync1_q;
         code_p_q <= code_s_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Event decode
   // ---------------------------------------------------------------------------
   logic code_nz;
   logic start;
   logic abort;

   state_t        state_q,    state_d;
   logic [1:0]    cur_code_q, cur_code_d;
   logic [CW-1:0] half_cnt_q, half_cnt_d;
   logic [CW-1:0] dur_cnt_q,  dur_cnt_d;
   logic          phase_q,    phase_d;
   logic          speaker_q,  speaker_d;
   logic          busy_q,     busy_d;
   logic [CW-1:0] half_ld;    // reload value for the note now playing
   logic          in_note_d;

   assign code_nz = (code_s_q != CODE_STOP);
   assign start   = code_nz && ((code_s_q != code_p_q) || trig);
   // start and abort are mutually exclusive: start needs a non-zero code.
   assign abort   = !code_nz && (state_q != S_IDLE);

   // The second go note is always the high tone; the first note follows
   // the code that started it.
   assign half_ld = ((state_q == S_NOTE2) || (cur_code_q == CODE_PING))
                    ? PING_LD : PONG_LD;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets a default before any branch, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cur_code_d = cur_code_q;
      half_cnt_d = half_cnt_q;
      dur_cnt_d  = dur_cnt_q;
      phase_d    = phase_q;

      if (start) begin
         state_d    = S_NOTE1;
         cur_code_d = code_s_q;
         half_cnt_d = (code_s_q == CODE_PING) ? PING_LD : PONG_LD;
         dur_cnt_d  = DUR_LD;
         phase_d    = 1'b1;
      end else if (abort) begin
         state_d    = S_IDLE;
         cur_code_d = CODE_STOP;
         phase_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               // Wait for a start event.
            end

            S_NOTE1, S_NOTE2: begin
               // Tone generator: toggle phase every half-period.
               if (half_cnt_q == '0) begin
                  phase_d    = !phase_q;
                  half_cnt_d = half_ld;
               end else begin
                  half_cnt_d = half_cnt_q - ONE;
               end

               if (dur_cnt_q == '0) begin
                  if ((state_q == S_NOTE1) && (cur_code_q == CODE_GO)) begin
                     state_d   = S_GAP;
                     dur_cnt_d = GAP_LD;
                     phase_d   = 1'b0;
                  end else begin
                     state_d    = S_IDLE;
                     cur_code_d = CODE_STOP;
                     phase_d    = 1'b0;
                  end
               end else begin
                  dur_cnt_d = dur_cnt_q - ONE;
               end
            end

            S_GAP: begin
               if (dur_cnt_q == '0) begin
                  state_d    = S_NOTE2;
                  half_cnt_d = PING_LD;
                  dur_cnt_d  = DUR_LD;
                  phase_d    = 1'b1;
               end else begin
                  dur_cnt_d = dur_cnt_q - ONE;
               end
            end

            default: begin
               state_d    = S_IDLE;
               cur_code_d = CODE_STOP;
            end
         endcase
      end

      // Outputs are registered from the next state, so they change on the
      // same edge as the state they describe, with no extra cycle of lag.
      in_note_d = (state_d == S_NOTE1) || (state_d == S_NOTE2);
      speaker_d = phase_d && in_note_d && !mute;
      busy_d    = (state_d != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q    <= S_IDLE;
         cur_code_q <= CODE_STOP;
         half_cnt_q <= '0;
         dur_cnt_q  <= '0;
         phase_q    <= 1'b0;
         speaker_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_code_q <= cur_code_d;
         half_cnt_q <= half_cnt_d;
         dur_cnt_q  <= dur_cnt_d;
         phase_q    <= phase_d;
         speaker_q  <= speaker_d;
         busy_q     <= busy_d;
      end
   end

   assign speaker  = speaker_q;
   assign busy     = busy_q;
   assign cur_code = cur_code_q;

endmodule

// File: tb/tb_sound_pong.sv
// -----------------------------------------------------------------------------
// tb_sound_pong
//
// Bench for sound_pong with short tones (PING_HALF=4, PONG_HALF=8, DUR=40,
// GAP=10). A behavioural model describes each sound as "started at edge s
// with code c": the outputs after edge s+n follow directly from n. The model
// is compared with the DUT after every clock edge; directed literal checks
// pin the key instants (latencies, note ends, gap, mute, preempt, abort,
// asynchronous reset).
// -----------------------------------------------------------------------------
module tb_sound_pong;

   localparam int PING = 4;
   localparam int PONG = 8;
   localparam int DUR  = 40;
   localparam int GAP  = 10;

   logic       clk = 1'b0;
   logic       clr;
   logic [1:0] code_sound;
   logic       mute;
   logic       trig;
   logic       speaker;
   logic       busy;
   logic [1:0] cur_code;

   int n_cmp = 0;
   int n_bad = 0;

   sound_pong #(
      .PING_HALF (PING),
      .PONG_HALF (PONG),
      .DUR       (DUR),
      .GAP       (GAP),
      .CW        (24)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .code_sound (code_sound),
      .mute       (mute),
      .trig       (trig),
      .speaker    (speaker),
      .busy       (busy),
      .cur_code   (cur_code)
   );

   always #5 clk = ~clk;

   // Compare {speaker, busy, cur_code} against an expected 4-bit value.
   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: {speaker,busy,cur_code} got %b want %b",
                  name, $time, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   function automatic int total_len(input logic [1:0] c);
      return (c == 2'b11) ? (2 * DUR + GAP) : DUR;
   endfunction

   // Tone level n cycles into a sound that started with code c.
   function automatic bit tone_high(input logic [1:0] c, input int n);
      int h;
      if (n < DUR) begin
         h = (c == 2'b10) ? PING : PONG;
         return ((n / h) % 2) == 0;
      end else if (n < DUR + GAP) begin
         return 1'b0;
      end
      return (((n - DUR - GAP) / PING) % 2) == 0;
   endfunction

   logic [1:0] d1, d2, d3;     // code_sound as sampled 1, 2, 3 edges ago
   bit         playing;
   logic [1:0] m_code;
   int         m_n;
   logic       e_spk, e_busy;
   logic [1:0] e_code;

   initial begin
      logic [1:0] cs, cp;
      bit         st;
      d1 = 2'b00; d2 = 2'b00; d3 = 2'b00;
      playing = 1'b0; m_code = 2'b00; m_n = 0;
      e_spk = 1'b0; e_busy = 1'b0; e_code = 2'b00;
      forever begin
         @(posedge clk);
         if (clr) begin
            d1 = 2'b00; d2 = 2'b00; d3 = 2'b00;
            playing = 1'b0; m_n = 0;
         end else begin
            // The sequencer reacts to the pin value two edges late and
            // detects a change against the value one edge before that.
            cs = d2;
            cp = d3;
            d3 = d2; d2 = d1; d1 = code_sound;
            st = (cs != 2'b00) && ((cs != cp) || trig);
            if (st) begin
               playing = 1'b1;
               m_code  = cs;
               m_n     = 0;
            end else if (playing) begin
               if (cs == 2'b00) begin
                  playing = 1'b0;
               end else begin
                  m_n++;
                  if (m_n >= total_len(m_code)) playing = 1'b0;
               end
            end
         end
         e_busy = playing;
         e_code = playing ? m_code : 2'b00;
         e_spk  = playing && tone_high(m_code, m_n) && !mute;
      end
   end

   // Per-cycle comparison, 2 time units after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         check("cycle", {speaker, busy, cur_code}, {e_spk, e_busy, e_code});
      end
   end

   // Advance n rising edges and settle just after the last one.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   // ---------------------------------------------------------------------------
   // Directed stimulus; inputs change on falling edges
   // ---------------------------------------------------------------------------
   initial begin
      clr = 1'b1; code_sound = 2'b00; mute = 1'b0; trig = 1'b0;

      // 1. Reset and idle release
      edges(3);
      check("reset_vals", {speaker, busy, cur_code}, 4'b0000);
      @(negedge clk) clr = 1'b0;
      edges(100);
      check("idle_100", {speaker, busy, cur_code}, 4'b0000);

      // 2. Ping: busy from edge k+2 for 40 cycles, 4 high / 4 low
      @(negedge clk) code_sound = 2'b10;
      edges(2);  check("ping_lat_k1", {speaker, busy, cur_code}, 4'b0000);
      edges(1);  check("ping_start",  {speaker, busy, cur_code}, 4'b1110);
      edges(3);  check("ping_hi_end", {speaker, busy, cur_code}, 4'b1110);
      edges(1);  check("ping_lo",     {speaker, busy, cur_code}, 4'b0110);
      edges(35); check("ping_last",   {speaker, busy, cur_code}, 4'b0110);
      edges(1);  check("ping_done",   {speaker, busy, cur_code}, 4'b0000);
      @(negedge clk) code_sound = 2'b00;
      edges(10);

      // 3. Go: 40 low-tone cycles, 10 gap, 40 high-tone cycles
      @(negedge clk) code_sound = 2'b11;
      edges(3);  check("go_start",    {speaker, busy, cur_code}, 4'b1111);
      edges(40); check("go_gap",      {speaker, busy, cur_code}, 4'b0111);
      edges(10); check("go_note2",    {speaker, busy, cur_code}, 4'b1111);
      edges(39); check("go_last",     {speaker, busy, cur_code}, 4'b0111);
      edges(1);  check("go_done",     {speaker, busy, cur_code}, 4'b0000);
      @(negedge clk) code_sound = 2'b00;
      edges(10);

      // 4. Pong held, replayed by trig; second replay muted
      @(negedge clk) code_sound = 2'b01;
      edges(3);  check("pong_start",  {speaker, busy, cur_code}, 4'b1101);
      edges(60);
      @(negedge clk) trig = 1'b1;
      edges(1);  check("trig1_lat",   {speaker, busy, cur_code}, 4'b1101);
      @(negedge clk) trig = 1'b0;
      edges(39); check("trig1_last",  {speaker, busy, cur_code}, 4'b1101);
      edges(1);  check("trig1_done",  {speaker, busy, cur_code}, 4'b0000);
      edges(18);
      @(negedge clk) begin trig = 1'b1; mute = 1'b1; end
      edges(1);  check("mute_start",  {speaker, busy, cur_code}, 4'b0101);
      @(negedge clk) trig = 1'b0;
      edges(39); check("mute_last",   {speaker, busy, cur_code}, 4'b0101);
      edges(1);  check("mute_done",   {speaker, busy, cur_code}, 4'b0000);
      @(negedge clk) mute = 1'b0;
      edges(5);

      // 5a. Preempt a pong note with ping at cycle 15
      @(negedge clk) trig = 1'b1;
      edges(1);  check("pre_pong",    {speaker, busy, cur_code}, 4'b1101);
      @(negedge clk) trig = 1'b0;
      edges(14); check("pre_pong14",  {speaker, busy, cur_code}, 4'b0101);
      @(negedge clk) code_sound = 2'b10;
      edges(2);  check("pre_old",     {speaker, busy, cur_code}, 4'b1101);
      edges(1);  check("pre_restart", {speaker, busy, cur_code}, 4'b1110);
      edges(4);  check("pre_lo",      {speaker, busy, cur_code}, 4'b0110);
      edges(35); check("pre_last",    {speaker, busy, cur_code}, 4'b0110);
      edges(1);  check("pre_done",    {speaker, busy, cur_code}, 4'b0000);

      // 5b. Abort a ping note by returning the code to 00
      @(negedge clk) trig = 1'b1;
      edges(1);  check("abt_start",   {speaker, busy, cur_code}, 4'b1110);
      @(negedge clk) trig = 1'b0;
      edges(9);  check("abt_mid",     {speaker, busy, cur_code}, 4'b1110);
      @(negedge clk) code_sound = 2'b00;
      edges(2);  check("abt_pending", {speaker, busy, cur_code}, 4'b1110);
      edges(1);  check("abt_done",    {speaker, busy, cur_code}, 4'b0000);
      edges(10);

      // 6. Reset during the go gap, then restart with code held at 11
      @(negedge clk) code_sound = 2'b11;
      edges(3);  check("rst_go",      {speaker, busy, cur_code}, 4'b1111);
      edges(44); check("rst_in_gap",  {speaker, busy, cur_code}, 4'b0111);
      @(negedge clk) clr = 1'b1;
      #1;        check("rst_async",   {speaker, busy, cur_code}, 4'b0000);
      edges(3);  check("rst_held",    {speaker, busy, cur_code}, 4'b0000);
      @(negedge clk) clr = 1'b0;
      edges(2);  check("rel_quiet",   {speaker, busy, cur_code}, 4'b0000);
      edges(1);  check("rel_go",      {speaker, busy, cur_code}, 4'b1111);
      edges(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
